// File: rtl/arm_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package arm_pkg;

  localparam int WORD_BYTES = 4;
  localparam int NUM_REGS   = 16;

  // Sequencer states; exported on the debug port so checkers can follow the walk.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_LATCH = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Addressing mode, encoded as {pre, up}.
  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } am_e;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Memory port and register-bank port of the LDM/STM sequencer.
//
// Memory handshake: the sequencer holds mem_req=1 with mem_addr/mem_we/mem_wdata
// stable until a cycle in which mem_ready=1; that cycle completes the beat, and
// mem_rdata is only meaningful in it. mem_ready while mem_req=0 has no effect.
// Bank write: rb_latch=1 writes rb_wdata to register rb_rd in that single cycle.
interface ldm_stm_seq_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [3:0]        rb_rsel;
  logic [DATA_W-1:0] rb_rdata;
  logic              rb_latch;
  logic [3:0]        rb_rd;
  logic [DATA_W-1:0] rb_wdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, rb_rsel, rb_latch, rb_rd, rb_wdata,
    input  mem_ready, mem_rdata, rb_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, rb_rsel, rb_latch, rb_rd, rb_wdata,
    output mem_ready, mem_rdata, rb_rdata
  );
endinterface

// File: rtl/ldm_stm_seq_prio_enc16.sv
// Lowest-set-bit encoder used to pick the next register from the pending list.
module prio_enc16
  import arm_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec,
  output logic [3:0]          idx,
  output logic                valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// ARMv4 LDM/STM block-transfer sequencer: walks the register list in ascending
// order, one word per listed register, then optionally writes the base back.
module ldm_stm_seq
  import arm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter bit FORCE_ALIGN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_load,
  input  logic [15:0]         reg_list,
  input  logic [3:0]          base_reg,
  input  logic [DATA_W-1:0]   base_addr,
  input  logic                up,
  input  logic                pre,
  input  logic                wback,
  ldm_stm_seq_if.master       bus,
  output logic                busy,
  output logic                done,
  output state_e              dbg_state
);

  state_e            state_q, state_d;
  logic [15:0]       pending_q, pending_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              ld_q;
  logic [3:0]        base_reg_q;
  logic [DATA_W-1:0] new_base_q;
  logic              do_wb_q;
  logic [DATA_W-1:0] rdata_q;

  logic [4:0]        cnt;
  logic [DATA_W-1:0] span;
  logic [DATA_W-1:0] start_addr;
  logic [DATA_W-1:0] new_base;
  logic [3:0]        cur;
  logic              cur_valid;
  logic [15:0]       rest;
  logic              do_wb;

  prio_enc16 u_enc (
    .vec   (pending_q),
    .idx   (cur),
    .valid (cur_valid)
  );

  // Pending list with the register now being transferred removed.
  assign rest = pending_q & ~(16'(1) << cur);

  // Number of listed registers.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + 5'(reg_list[i]);
    end
  end

  // Lowest address used and the updated base; decrementing modes start low so
  // the lowest register always lands on the lowest address.
  always_comb begin
    span     = DATA_W'(cnt) * DATA_W'(WORD_BYTES);
    new_base = up ? (base_addr + span) : (base_addr - span);
    case (am_e'({pre, up}))
      AM_IA:   start_addr = base_addr;
      AM_IB:   start_addr = base_addr + DATA_W'(WORD_BYTES);
      AM_DA:   start_addr = base_addr - span + DATA_W'(WORD_BYTES);
      default: start_addr = base_addr - span;
    endcase
    // A loaded base register takes priority over the writeback value.
    do_wb = wback && (reg_list != 16'd0) && !(is_load && reg_list[base_reg]);
  end

  // Next state and all port outputs, decoded from the registered state.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    addr_d        = addr_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rb_rsel   = 4'd0;
    bus.rb_latch  = 1'b0;
    bus.rb_rd     = 4'd0;
    bus.rb_wdata  = '0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d = reg_list;
          addr_d    = start_addr;
          state_d   = (reg_list == 16'd0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        bus.mem_req  = cur_valid;
        bus.mem_we   = !ld_q;
        bus.mem_addr = FORCE_ALIGN ? {addr_q[DATA_W-1:2], 2'b00} : addr_q;
        bus.rb_rsel  = cur;
        bus.mem_wdata = ld_q ? '0 : bus.rb_rdata;
        if (bus.mem_ready) begin
          addr_d = addr_q + DATA_W'(WORD_BYTES);
          if (ld_q) begin
            state_d = S_LATCH;
          end else begin
            pending_d = rest;
            state_d   = (rest != 16'd0) ? S_XFER : (do_wb_q ? S_WB : S_DONE);
          end
        end
      end
      S_LATCH: begin
        bus.rb_latch = 1'b1;
        bus.rb_rd    = cur;
        bus.rb_wdata = rdata_q;
        pending_d    = rest;
        state_d      = (rest != 16'd0) ? S_XFER : (do_wb_q ? S_WB : S_DONE);
      end
      S_WB: begin
        bus.rb_latch = 1'b1;
        bus.rb_rd    = base_reg_q;
        bus.rb_wdata = new_base_q;
        state_d      = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_XFER) || (state_q == S_LATCH) || (state_q == S_WB);
  assign dbg_state = state_q;

  // State register plus operands captured at launch and load data per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pending_q  <= 16'd0;
      addr_q     <= '0;
      ld_q       <= 1'b0;
      base_reg_q <= 4'd0;
      new_base_q <= '0;
      do_wb_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      if (state_q == S_IDLE && start) begin
        ld_q       <= is_load;
        base_reg_q <= base_reg;
        new_base_q <= new_base;
        do_wb_q    <= do_wb;
      end
      if (state_q == S_XFER && bus.mem_ready && ld_q) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule
